// File: rtl/mem_stage_pkg.sv
// Shared definitions for the RV32I memory stage: funct3 access widths,
// FSM state encoding and the alignment-fault helper.
package mem_stage_pkg;

    localparam int XLEN = 32;
    localparam int RIDX = 5;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    // Reserved widths fault like a misaligned access so they never reach memory.
    function automatic logic access_fault(input logic [2:0] f3, input logic [1:0] lo);
        logic fault;
        case (f3)
            F3_B, F3_BU: fault = 1'b0;
            F3_H, F3_HU: fault = lo[0];
            F3_W:        fault = (lo != 2'b00);
            default:     fault = 1'b1;
        endcase
        return fault;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Signal bundle around the memory stage: EX input, data-memory port and
// writeback output. master is the stage's view, slave the surroundings'.
interface mem_stage_if;

    logic                               in_valid;
    logic                               in_ready;
    logic [mem_stage_pkg::XLEN-1:0]     alu_result;
    logic [mem_stage_pkg::XLEN-1:0]     store_data;
    logic                               is_load;
    logic                               is_store;
    logic [2:0]                         funct3;
    logic [mem_stage_pkg::RIDX-1:0]     rd_in;
    logic                               reg_write_in;

    logic                               dmem_req;
    logic                               dmem_we;
    logic [mem_stage_pkg::XLEN-1:0]     dmem_addr;
    logic [mem_stage_pkg::XLEN-1:0]     dmem_wdata;
    logic [3:0]                         dmem_wstrb;
    logic                               dmem_gnt;
    logic                               dmem_rvalid;
    logic [mem_stage_pkg::XLEN-1:0]     dmem_rdata;

    logic                               out_valid;
    logic                               out_ready;
    logic [mem_stage_pkg::XLEN-1:0]     wb_data;
    logic [mem_stage_pkg::RIDX-1:0]     rd_out;
    logic                               reg_write_out;
    logic                               misalign;

    modport master (
        input  in_valid, alu_result, store_data, is_load, is_store, funct3,
               rd_in, reg_write_in, dmem_gnt, dmem_rvalid, dmem_rdata, out_ready,
        output in_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
               out_valid, wb_data, rd_out, reg_write_out, misalign
    );

    modport slave (
        output in_valid, alu_result, store_data, is_load, is_store, funct3,
               rd_in, reg_write_in, dmem_gnt, dmem_rvalid, dmem_rdata, out_ready,
        input  in_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
               out_valid, wb_data, rd_out, reg_write_out, misalign
    );

endinterface

// File: rtl/mem_stage_load_align.sv
// Load data alignment: picks the addressed byte/halfword lane out of the
// returned word and sign- or zero-extends it according to funct3.
module mem_stage_load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane select followed by width/sign extension
    always_comb begin
        w_byte = 8'h00;
        w_half = 16'h0000;
        o_data = i_rdata;
        case (i_addr_lo)
            2'b00:   w_byte = i_rdata[7:0];
            2'b01:   w_byte = i_rdata[15:8];
            2'b10:   w_byte = i_rdata[23:16];
            2'b11:   w_byte = i_rdata[31:24];
            default: w_byte = 8'h00;
        endcase
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
        case (i_funct3)
            F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_data = {24'h000000, w_byte};
            F3_H:    o_data = {{16{w_half[15]}}, w_half};
            F3_HU:   o_data = {16'h0000, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory stage: accepts one EX result at a time, performs at most one
// data-memory access and hands the writeback payload on with a valid/ready pair.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    mem_stage_if.master bus
);

    state_e      r_state;
    state_e      w_state_nxt;
    logic        r_is_load;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic [2:0]  r_funct3;
    logic [4:0]  r_rd;
    logic        r_reg_write;
    logic        r_misalign;
    logic [31:0] r_wb_data;

    logic        w_mem_op;
    logic        w_fault;
    logic        w_accept;
    logic        w_load_done;
    logic [31:0] w_st_wdata;
    logic [3:0]  w_st_wstrb;
    logic [31:0] w_load_data;

    assign w_mem_op    = bus.is_load ^ bus.is_store;
    assign w_fault     = w_mem_op & access_fault(bus.funct3, bus.alu_result[1:0]);
    assign w_accept    = (r_state == ST_IDLE) & bus.in_valid;
    assign w_load_done = r_is_load & bus.dmem_rvalid &
                         (((r_state == ST_REQ) & bus.dmem_gnt) | (r_state == ST_WAIT));

    mem_stage_load_align u_load_align (
        .i_rdata   (bus.dmem_rdata),
        .i_addr_lo (r_addr[1:0]),
        .i_funct3  (r_funct3),
        .o_data    (w_load_data)
    );

    // Store lane replication and byte strobes from the incoming address
    always_comb begin
        w_st_wdata = bus.store_data;
        w_st_wstrb = 4'b1111;
        case (bus.funct3[1:0])
            2'b00: begin
                w_st_wdata = {4{bus.store_data[7:0]}};
                w_st_wstrb = 4'b0001 << bus.alu_result[1:0];
            end
            2'b01: begin
                w_st_wdata = {2{bus.store_data[15:0]}};
                w_st_wstrb = 4'b0011 << bus.alu_result[1:0];
            end
            default: begin
                w_st_wdata = bus.store_data;
                w_st_wstrb = 4'b1111;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    if (w_mem_op && !w_fault) w_state_nxt = ST_REQ;
                    else                      w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (bus.dmem_gnt) begin
                    if (!r_is_load || bus.dmem_rvalid) w_state_nxt = ST_DONE;
                    else                               w_state_nxt = ST_WAIT;
                end else begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (bus.dmem_rvalid) w_state_nxt = ST_DONE;
                else                 w_state_nxt = ST_WAIT;
            end
            ST_DONE: begin
                if (bus.out_ready) w_state_nxt = ST_IDLE;
                else               w_state_nxt = ST_DONE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Request/payload capture on accept; load data captured on response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_is_load   <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= 32'h0000_0000;
            r_wdata     <= 32'h0000_0000;
            r_wstrb     <= 4'b0000;
            r_funct3    <= 3'b000;
            r_rd        <= 5'd0;
            r_reg_write <= 1'b0;
            r_misalign  <= 1'b0;
            r_wb_data   <= 32'h0000_0000;
        end else if (w_accept) begin
            r_is_load   <= bus.is_load & ~bus.is_store & ~w_fault;
            r_we        <= bus.is_store & ~bus.is_load & ~w_fault;
            r_addr      <= bus.alu_result;
            r_wdata     <= (bus.is_store & ~bus.is_load) ? w_st_wdata : 32'h0000_0000;
            r_wstrb     <= (bus.is_store & ~bus.is_load) ? w_st_wstrb : 4'b0000;
            r_funct3    <= bus.funct3;
            r_rd        <= bus.rd_in;
            r_reg_write <= bus.reg_write_in & ~w_fault & ~(bus.is_store & ~bus.is_load);
            r_misalign  <= w_fault;
            r_wb_data   <= w_mem_op ? 32'h0000_0000 : bus.alu_result;
        end else if (w_load_done) begin
            r_wb_data   <= w_load_data;
        end
    end

    assign bus.in_ready      = (r_state == ST_IDLE);
    assign bus.dmem_req      = (r_state == ST_REQ);
    assign bus.dmem_we       = (r_state == ST_REQ) & r_we;
    assign bus.dmem_addr     = {r_addr[31:2], 2'b00};
    assign bus.dmem_wdata    = r_wdata;
    assign bus.dmem_wstrb    = r_wstrb;
    assign bus.out_valid     = (r_state == ST_DONE);
    assign bus.wb_data       = r_wb_data;
    assign bus.rd_out        = r_rd;
    assign bus.reg_write_out = (r_state == ST_DONE) & r_reg_write;
    assign bus.misalign      = (r_state == ST_DONE) & r_misalign;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: pass-through, loads, stores, misalignment,
// stalls and asynchronous reset during an outstanding load.
module tb_mem_stage;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    mem_stage_if bus ();

    mem_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_op(input logic [31:0] addr, input logic [31:0] sd,
                            input logic ld, input logic st, input logic [2:0] f3,
                            input logic [4:0] rd, input logic rw);
        bus.in_valid     = 1'b1;
        bus.alu_result   = addr;
        bus.store_data   = sd;
        bus.is_load      = ld;
        bus.is_store     = st;
        bus.funct3       = f3;
        bus.rd_in        = rd;
        bus.reg_write_in = rw;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b1;
        bus.in_valid = 1'b0;   bus.alu_result = 32'h0; bus.store_data = 32'h0;
        bus.is_load  = 1'b0;   bus.is_store   = 1'b0;  bus.funct3     = 3'b000;
        bus.rd_in    = 5'd0;   bus.reg_write_in = 1'b0;
        bus.dmem_gnt = 1'b0;   bus.dmem_rvalid = 1'b0; bus.dmem_rdata = 32'h0;
        bus.out_ready = 1'b1;
        #2 rst_n = 1'b0;
        step(); step();
        check("rst_in_ready",  bus.in_ready,  32'd1);
        check("rst_out_valid", bus.out_valid, 32'd0);
        check("rst_dmem_req",  bus.dmem_req,  32'd0);
        check("rst_wb_data",   bus.wb_data,   32'h0);
        #3 rst_n = 1'b1;
        step();

        // Pass-through, 1-cycle latency
        drive_op(32'h0000_1234, 32'h0, 1'b0, 1'b0, 3'b000, 5'd5, 1'b1);
        step();
        bus.in_valid = 1'b0;
        check("pt_out_valid", bus.out_valid, 32'd1);
        check("pt_wb_data",   bus.wb_data,   32'h0000_1234);
        check("pt_rd_out",    bus.rd_out,    32'd5);
        check("pt_regwr",     bus.reg_write_out, 32'd1);
        check("pt_dmem_req",  bus.dmem_req,  32'd0);
        check("pt_in_ready",  bus.in_ready,  32'd0);
        step();
        check("pt_idle",      bus.in_ready,  32'd1);

        // LB at 0x103, separate grant and response
        drive_op(32'h0000_0103, 32'h0, 1'b1, 1'b0, 3'b000, 5'd7, 1'b1);
        step();
        bus.in_valid = 1'b0;
        check("lb_req",   bus.dmem_req,  32'd1);
        check("lb_addr",  bus.dmem_addr, 32'h0000_0100);
        check("lb_we",    bus.dmem_we,   32'd0);
        bus.dmem_gnt = 1'b1;
        step();
        bus.dmem_gnt = 1'b0;
        check("lb_wait_req", bus.dmem_req,  32'd0);
        check("lb_wait_ov",  bus.out_valid, 32'd0);
        bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'h80FF_0000;
        step();
        bus.dmem_rvalid = 1'b0;
        check("lb_ov",    bus.out_valid, 32'd1);
        check("lb_data",  bus.wb_data,   32'hFFFF_FF80);
        check("lb_regwr", bus.reg_write_out, 32'd1);
        step();

        // LBU at 0x103, grant and response in the same cycle
        drive_op(32'h0000_0103, 32'h0, 1'b1, 1'b0, 3'b100, 5'd8, 1'b1);
        step();
        bus.in_valid = 1'b0;
        bus.dmem_gnt = 1'b1; bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'h80FF_0000;
        step();
        bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b0;
        check("lbu_ov",   bus.out_valid, 32'd1);
        check("lbu_data", bus.wb_data,   32'h0000_0080);
        step();

        // SH at 0x102
        drive_op(32'h0000_0102, 32'h0000_ABCD, 1'b0, 1'b1, 3'b001, 5'd9, 1'b1);
        step();
        bus.in_valid = 1'b0;
        check("sh_req",   bus.dmem_req,   32'd1);
        check("sh_we",    bus.dmem_we,    32'd1);
        check("sh_addr",  bus.dmem_addr,  32'h0000_0100);
        check("sh_wstrb", bus.dmem_wstrb, 32'hC);
        check("sh_wdata", bus.dmem_wdata, 32'hABCD_ABCD);
        bus.dmem_gnt = 1'b1;
        step();
        bus.dmem_gnt = 1'b0;
        check("sh_ov",    bus.out_valid,     32'd1);
        check("sh_regwr", bus.reg_write_out, 32'd0);
        check("sh_noreq", bus.dmem_req,      32'd0);
        step();

        // SB at 0x001
        drive_op(32'h0000_0001, 32'h1234_5655, 1'b0, 1'b1, 3'b000, 5'd1, 1'b0);
        step();
        bus.in_valid = 1'b0;
        check("sb_wstrb", bus.dmem_wstrb, 32'h2);
        check("sb_wdata", bus.dmem_wdata, 32'h5555_5555);
        bus.dmem_gnt = 1'b1;
        step();
        bus.dmem_gnt = 1'b0;
        step();

        // LW at 0x202: misaligned, never requests
        drive_op(32'h0000_0202, 32'h0, 1'b1, 1'b0, 3'b010, 5'd3, 1'b1);
        check("lw_mis_pre_req", bus.dmem_req, 32'd0);
        step();
        bus.in_valid = 1'b0;
        check("lw_mis_req",   bus.dmem_req,      32'd0);
        check("lw_mis_flag",  bus.misalign,      32'd1);
        check("lw_mis_regwr", bus.reg_write_out, 32'd0);
        check("lw_mis_ov",    bus.out_valid,     32'd1);
        step();

        // Reserved funct3 011 on an aligned load faults as well
        drive_op(32'h0000_0000, 32'h0, 1'b1, 1'b0, 3'b011, 5'd3, 1'b1);
        step();
        bus.in_valid = 1'b0;
        check("f3_bad_flag", bus.misalign, 32'd1);
        check("f3_bad_req",  bus.dmem_req, 32'd0);
        step();

        // Load and store both set: plain pass-through
        drive_op(32'h0000_0301, 32'h0, 1'b1, 1'b1, 3'b010, 5'd4, 1'b1);
        step();
        bus.in_valid = 1'b0;
        check("both_data", bus.wb_data,  32'h0000_0301);
        check("both_req",  bus.dmem_req, 32'd0);
        check("both_mis",  bus.misalign, 32'd0);
        step();

        // Stalls: LH at 0x1002, grant after 3 cycles, response 2 later, out_ready low 2
        bus.out_ready = 1'b0;
        drive_op(32'h0000_1002, 32'h0, 1'b1, 1'b0, 3'b001, 5'd11, 1'b1);
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("stl_req",   bus.dmem_req,  32'd1);
            check("stl_addr",  bus.dmem_addr, 32'h0000_1000);
            check("stl_inrdy", bus.in_ready,  32'd0);
            step();
        end
        bus.dmem_gnt = 1'b1;
        check("stl_req_gnt", bus.dmem_req, 32'd1);
        step();
        bus.dmem_gnt = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("stl_wait_ov",  bus.out_valid, 32'd0);
            check("stl_wait_req", bus.dmem_req,  32'd0);
            check("stl_wait_rdy", bus.in_ready,  32'd0);
            step();
        end
        bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'h8001_1234;
        step();
        bus.dmem_rvalid = 1'b0; bus.dmem_rdata = 32'h0;
        drive_op(32'h0000_DEAD, 32'h0, 1'b0, 1'b0, 3'b000, 5'd12, 1'b1);
        for (int i = 0; i < 2; i++) begin
            check("stl_done_ov",   bus.out_valid, 32'd1);
            check("stl_done_data", bus.wb_data,   32'hFFFF_8001);
            check("stl_done_rd",   bus.rd_out,    32'd11);
            check("stl_done_rdy",  bus.in_ready,  32'd0);
            step();
        end
        bus.out_ready = 1'b1;
        step();
        check("b2b_idle", bus.in_ready, 32'd1);
        step();
        bus.in_valid = 1'b0;
        check("b2b_data", bus.wb_data, 32'h0000_DEAD);
        check("b2b_ov",   bus.out_valid, 32'd1);
        step();

        // Reset during WAIT
        drive_op(32'h0000_0300, 32'h0, 1'b1, 1'b0, 3'b010, 5'd13, 1'b1);
        step();
        bus.in_valid = 1'b0;
        bus.dmem_gnt = 1'b1;
        step();
        bus.dmem_gnt = 1'b0;
        check("rw_pre_addr", bus.dmem_addr, 32'h0000_0300);
        #2 rst_n = 1'b0;
        #1;
        check("rw_req",   bus.dmem_req,  32'd0);
        check("rw_ov",    bus.out_valid, 32'd0);
        check("rw_addr",  bus.dmem_addr, 32'h0);
        check("rw_rd",    bus.rd_out,    32'd0);
        check("rw_inrdy", bus.in_ready,  32'd1);
        #2 rst_n = 1'b1;
        bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'hFFFF_FFFF;
        step();
        bus.dmem_rvalid = 1'b0;
        check("rw_late_ov",   bus.out_valid, 32'd0);
        check("rw_late_data", bus.wb_data,   32'h0);
        check("rw_late_rdy",  bus.in_ready,  32'd1);
        drive_op(32'h0000_0302, 32'h0, 1'b1, 1'b0, 3'b101, 5'd14, 1'b1);
        step();
        bus.in_valid = 1'b0;
        check("rw_next_req", bus.dmem_req, 32'd1);
        bus.dmem_gnt = 1'b1; bus.dmem_rvalid = 1'b1; bus.dmem_rdata = 32'h8001_0000;
        step();
        bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b0;
        check("rw_next_data", bus.wb_data, 32'h0000_8001);
        check("rw_next_rd",   bus.rd_out,  32'd14);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
